// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
// Sequences one ALU operation: load A/B, hold send for ALU_WAIT cycles, capture result, return it.
// Result appears ALU_WAIT+1 cycles after request accept; a stalled response holds the FSM in RESP and blocks new requests.
module alu_op_sequencer #(
   parameter int ALU_WAIT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   input  logic [3:0] req_op,
   output logic [7:0] data_a_out,
   output logic [7:0] data_b_out,
   output logic       load_a,
   output logic       load_b,
   output logic       send_a,
   output logic       send_alu,
   output logic [3:0] opcode_out,
   input  logic [7:0] alu_result,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic [7:0] op_count
);

   typedef enum logic [1:0] {IDLE, LOAD, ISSUE, RESP} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT - 1);

   state_t     state;
   state_t     nextState;
   logic [3:0] waitCnt;
   logic [7:0] opA;
   logic [7:0] opB;
   logic [3:0] opCode;
   logic [7:0] rspData;
   logic [7:0] opCount;
   logic       waitDone;

   assign waitDone = (waitCnt == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Every strobe is a pure decode of the state register, so reset clears them immediately.
   always_comb begin
      nextState = state;
      req_ready = 1'b0;
      load_a    = 1'b0;
      load_b    = 1'b0;
      send_a    = 1'b0;
      send_alu  = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) nextState = LOAD;
         end
         LOAD: begin
            load_a    = 1'b1;
            load_b    = 1'b1;
            nextState = ISSUE;
         end
         ISSUE: begin
            send_a   = 1'b1;
            send_alu = 1'b1;
            if (waitDone) nextState = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opA     <= 8'h00;
         opB     <= 8'h00;
         opCode  <= 4'h0;
         waitCnt <= 4'h0;
         rspData <= 8'h00;
         opCount <= 8'h00;
      end else begin
         if (state == IDLE && req_valid) begin
            opA    <= req_a;
            opB    <= req_b;
            opCode <= req_op;
         end
         if (state == LOAD) begin
            waitCnt <= WAIT_INIT;
         end else if (state == ISSUE && !waitDone) begin
            waitCnt <= waitCnt - 4'd1;
         end
         // alu_result is only trusted on the last ISSUE edge, after the full settle time.
         if (state == ISSUE && waitDone) begin
            rspData <= alu_result;
         end
         if (state == RESP && rsp_ready) begin
            opCount <= opCount + 8'd1;
         end
      end
   end

   assign data_a_out = opA;
   assign data_b_out = opB;
   assign opcode_out = opCode;
   assign rsp_data   = rspData;
   assign op_count   = opCount;

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for alu_op_sequencer: default build plus an ALU_WAIT=1 build sharing clock and reset.
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       reqValid, reqReady, loadA, loadB, sendA, sendAlu, rspValid, rspReady;
   logic [7:0] reqA, reqB, dataA, dataB, aluResult, rspData, opCount;
   logic [3:0] reqOp, opcode;

   logic       reqValid1, reqReady1, loadA1, loadB1, sendA1, sendAlu1, rspValid1, rspReady1;
   logic [7:0] reqA1, reqB1, dataA1, dataB1, aluResult1, rspData1, opCount1;
   logic [3:0] reqOp1, opcode1;

   int nChecks = 0;
   int nFails  = 0;
   int cycle   = 0;
   logic [7:0] expQ[$];
   logic [7:0] expQ1[$];

   function automatic logic [7:0] aluModel(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return 8'h00;
      endcase
   endfunction

   assign aluResult  = aluModel(opcode, dataA, dataB);
   assign aluResult1 = aluModel(opcode1, dataA1, dataB1);

   alu_op_sequencer #(.ALU_WAIT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(reqValid), .req_ready(reqReady),
      .req_a(reqA), .req_b(reqB), .req_op(reqOp),
      .data_a_out(dataA), .data_b_out(dataB),
      .load_a(loadA), .load_b(loadB), .send_a(sendA), .send_alu(sendAlu),
      .opcode_out(opcode), .alu_result(aluResult),
      .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_data(rspData),
      .op_count(opCount)
   );

   alu_op_sequencer #(.ALU_WAIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(reqValid1), .req_ready(reqReady1),
      .req_a(reqA1), .req_b(reqB1), .req_op(reqOp1),
      .data_a_out(dataA1), .data_b_out(dataB1),
      .load_a(loadA1), .load_b(loadB1), .send_a(sendA1), .send_alu(sendAlu1),
      .opcode_out(opcode1), .alu_result(aluResult1),
      .rsp_valid(rspValid1), .rsp_ready(rspReady1), .rsp_data(rspData1),
      .op_count(opCount1)
   );

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: pop the expected result on every response handshake.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rspValid === 1'b1 && rspReady === 1'b1) begin
         if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL rsp_unexpected: got 0x%0h with empty scoreboard", rspData);
         end else begin
            check("rsp_data", rspData, expQ.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1 && rspValid1 === 1'b1 && rspReady1 === 1'b1) begin
         if (expQ1.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL rsp1_unexpected: got 0x%0h with empty scoreboard", rspData1);
         end else begin
            check("rsp1_data", rspData1, expQ1.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitValid(input string name);
      int n = 0;
      while (rspValid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(name, rspValid, 1);
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while (reqReady !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(name, reqReady, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int lastCyc;
      rst_n     = 1'b0;
      reqValid  = 1'b0; reqA  = 8'h00; reqB  = 8'h00; reqOp  = 4'h0; rspReady  = 1'b1;
      reqValid1 = 1'b0; reqA1 = 8'h00; reqB1 = 8'h00; reqOp1 = 4'h0; rspReady1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_req_ready", reqReady, 1);
      check("reset_strobes", {loadA, loadB, sendA, sendAlu, rspValid}, 0);
      check("reset_operands", {dataA, dataB, opcode}, 0);
      check("reset_rsp_data", rspData, 0);
      check("reset_op_count", opCount, 0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Basic op: 1 + 2
      reqA = 8'h01; reqB = 8'h02; reqOp = 4'h0; reqValid = 1'b1;
      expQ.push_back(8'h03);
      tick();
      reqValid = 1'b0;
      check("t1_load", {loadA, loadB, sendA, sendAlu}, 4'b1100);
      check("t1_busy", reqReady, 0);
      check("t1_operands", {dataA, dataB, opcode}, 20'h01020);
      tick();
      check("t1_issue1", {loadA, loadB, sendA, sendAlu, rspValid}, 5'b00110);
      tick();
      check("t1_issue2", {sendA, sendAlu, rspValid}, 3'b110);
      tick();
      check("t1_rsp", {sendAlu, rspValid}, 2'b01);
      check("t1_rsp_data", rspData, 8'h03);
      check("t1_count_pre", opCount, 0);
      tick();
      check("t1_rsp_done", rspValid, 0);
      check("t1_count", opCount, 1);
      check("t1_ready", reqReady, 1);

      // Backpressure: F0 + 0F held 6 cycles
      rspReady = 1'b0;
      reqA = 8'hF0; reqB = 8'h0F; reqOp = 4'h0; reqValid = 1'b1;
      expQ.push_back(8'hFF);
      tick();
      reqValid = 1'b0;
      waitValid("t2_valid");
      for (int i = 0; i < 6; i++) begin
         check("t2_hold_valid", rspValid, 1);
         check("t2_hold_data", rspData, 8'hFF);
         check("t2_hold_ready", reqReady, 0);
         check("t2_hold_count", opCount, 1);
         tick();
      end
      rspReady = 1'b1;
      tick();
      check("t2_count", opCount, 2);
      check("t2_done", rspValid, 0);

      // Request raised in LOAD is held off until IDLE
      reqA = 8'h01; reqB = 8'h03; reqOp = 4'h1; reqValid = 1'b1;
      expQ.push_back(8'hFE);
      tick();
      reqA = 8'h05; reqB = 8'h06; reqOp = 4'h4;
      expQ.push_back(8'h03);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("t3_hold_a", dataA, 8'h01);
         check("t3_ready", reqReady, (k == 4) ? 1 : 0);
      end
      tick();
      reqValid = 1'b0;
      check("t3_accept_a", dataA, 8'h05);
      check("t3_accept_op", opcode, 4'h4);
      check("t3_accept_load", loadA, 1);
      waitValid("t3_valid");
      tick();
      waitIdle("t3_idle");
      check("t3_count", opCount, 4);

      // Reset during the second ISSUE cycle
      reqA = 8'h09; reqB = 8'h09; reqOp = 4'h0; reqValid = 1'b1;
      tick();
      reqValid = 1'b0;
      tick();
      tick();
      check("t4_in_issue", sendAlu, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t4_strobes", {loadA, loadB, sendA, sendAlu, rspValid}, 0);
      check("t4_ready", reqReady, 1);
      check("t4_count", opCount, 0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t4_no_rsp", {rspValid, opCount}, 0);
      end

      // 256 back-to-back ops, op_count wraps to 0
      lastCyc = 0;
      for (int i = 0; i < 256; i++) begin
         reqA = 8'(i); reqB = 8'(i * 7); reqOp = 4'(i % 5); reqValid = 1'b1;
         waitIdle("t5_ready");
         expQ.push_back(aluModel(reqOp, reqA, reqB));
         if (i > 0) check("t5_spacing", cycle - lastCyc, 5);
         lastCyc = cycle;
         tick();
         if (i == 255) check("t5_count_255", opCount, 8'hFF);
      end
      reqValid = 1'b0;
      waitValid("t5_valid");
      tick();
      check("t5_wrap", opCount, 8'h00);
      check("t5_done", rspValid, 0);

      // ALU_WAIT=1 build: 7F + 01
      reqA1 = 8'h7F; reqB1 = 8'h01; reqOp1 = 4'h0; reqValid1 = 1'b1;
      expQ1.push_back(8'h80);
      tick();
      reqValid1 = 1'b0;
      check("t6_load", {loadA1, loadB1, sendAlu1}, 3'b110);
      tick();
      check("t6_issue", {sendA1, sendAlu1, rspValid1}, 3'b110);
      tick();
      check("t6_rsp", {sendAlu1, rspValid1}, 2'b01);
      check("t6_rsp_data", rspData1, 8'h80);
      tick();
      check("t6_done", rspValid1, 0);
      check("t6_count", opCount1, 1);

      tick();
      check("scoreboard_drained", expQ.size() + expQ1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Control sequencer that drives the A/B operand registers and the ALU enable on behalf of a requester. It accepts one operation (two 8-bit operands plus a 4-bit opcode) over a valid/ready request channel. It then issues the load and send strobes in order, waits a fixed settle time, captures the ALU result, and returns it over a valid/ready response channel. It sits between the instruction/host side and the ARegister/BRegister/ALU datapath, replacing bench-driven strobing.

## Interface
- ALU_WAIT, 2: cycles `send_alu` is held before the result is sampled; legal range 1..15.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  8  operand A.
- req_b  in  8  operand B.
- req_op  in  4  ALU opcode.
- data_a_out  out  8  operand to A register data input.
- data_b_out  out  8  operand to B register data input.
- load_a  out  1  A register load strobe.
- load_b  out  1  B register load strobe.
- send_a  out  1  A register send-to-ALU enable.
- send_alu  out  1  ALU output enable.
- opcode_out  out  4  opcode to ALU.
- alu_result  in  8  ALU result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  8  captured result.
- op_count  out  8  completed-operation counter.

## Operation
- States: IDLE, LOAD, ISSUE, RESP.
- IDLE:
  - `req_ready` = 1 (combinational on state only, never on `req_valid`).
  - On `req_valid` && `req_ready`, register `req_a`, `req_b` and `req_op` into the operand registers, then go to LOAD.
- LOAD (exactly one cycle):
  - `load_a` = `load_b` = 1, then go to ISSUE.
  - Load the wait counter with ALU_WAIT-1.
- ISSUE:
  - `send_a` = `send_alu` = 1; the counter decrements each cycle.
  - On the edge where counter = 0: `rsp_data` <= `alu_result`, `rsp_valid` <= 1, then go to RESP.
- RESP:
  - `rsp_valid` = 1 and `rsp_data` is held stable until `rsp_ready`.
  - On `rsp_valid` && `rsp_ready`: `rsp_valid` <= 0, `op_count` <= `op_count`+1 (wraps 255->0), then go to IDLE.
- Output hold:
  - `data_a_out`, `data_b_out` and `opcode_out` come from the operand registers and change only on a request handshake.
  - Between operations they hold the last values.
- Strobe exclusivity: all strobes are decoded from registered state (glitch-free).
  - Outside LOAD, `load_a` = `load_b` = 0.
  - Outside ISSUE, `send_a` = `send_alu` = 0.
- Request acceptance:
  - At most one operation is in flight.
  - `req_ready` = 0 in LOAD, ISSUE and RESP.
  - A `req_valid` raised during those states is ignored until IDLE.
- `alu_result` is sampled only on the final ISSUE edge; its value at all other times is don't-care.
- `rsp_data` is not cleared on handshake; it holds the last result until the next capture.

## Timing
- Reset values (asynchronous assertion, synchronous release): state IDLE; `req_ready` 1; `load_a`, `load_b`, `send_a`, `send_alu`, `rsp_valid` 0; `data_a_out`, `data_b_out`, `rsp_data`, `op_count` 0x00; `opcode_out` 0x0.
- Cycle numbering: request handshake on edge E0.
  - LOAD is the cycle after E0.
  - ISSUE spans ALU_WAIT cycles.
  - `rsp_valid` rises at edge E0+1+ALU_WAIT (E0+3 for default ALU_WAIT=2).
- Response with `rsp_ready` held high: `rsp_valid` is high for exactly one cycle, and `req_ready` is 1 in the cycle after the response handshake.
- Minimum request-to-request spacing: ALU_WAIT+3 cycles (5 for default).
- Backpressure: `rsp_ready` low holds RESP indefinitely; `rsp_data` stays constant and `op_count` does not change.
- Reset mid-operation (any state): immediate return to reset values. The in-flight operation is dropped and not counted, and no strobe may remain asserted after `rst_n` falls.
- ALU_WAIT=1: ISSUE lasts one cycle; `rsp_valid` rises at E0+2.

## Test plan
- Reset then A=0x01, B=0x02, op=0x0, ALU model returns A+B -> `load_a`/`load_b` high one cycle after E0, `send_alu` high 2 cycles, `rsp_valid` at E0+3 with `rsp_data`=0x03, `op_count`=1 after the handshake.
- Backpressure: A=0xF0, B=0x0F, `rsp_ready` low 6 cycles -> `rsp_valid` and `rsp_data`=0xFF held stable all 6 cycles, `req_ready`=0 throughout, `op_count` increments only on the handshake.
- Request during busy: second `req_valid` with A=0x05 asserted in LOAD and held -> ignored until IDLE; accepted on the first IDLE edge; `data_a_out` stays 0x01 until then.
- Reset in ISSUE: drop `rst_n` on the second ISSUE cycle -> all strobes 0 immediately, `rsp_valid` never rises, `op_count` stays 0, `req_ready`=1.
- op_count wrap: 256 back-to-back ops with `rsp_ready`=1 -> `op_count` reads 0x00; requests spaced exactly 5 cycles apart.
- ALU_WAIT=1 build: A=0x7F, B=0x01 -> `send_alu` high 1 cycle, `rsp_valid` at E0+2, `rsp_data`=0x80.
